count_display_scan: RTL and testbench

Display back-end for the 8-bit free-running counter. Consumes the counter's `count[7:0]` output and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) converter. It then drives a time-multiplexed, active-low 3-digit seven-segment display. Sits directly downstream of the counter, on the same clock and reset.

---
 rtl/count_disp_pkg.sv | 42 ++++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/count_display_scan.sv | 80 ++++++++
 tb/tb_count_display_scan.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/count_disp_pkg.sv
// Shared types and constants for the counter display back-end: converter states,
// active-low segment patterns and digit-enable codes.
package count_disp_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StLoad} conv_state_e;

  localparam int unsigned NUM_DIGITS = 3;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] AN_ONES     = 3'b110;
  localparam logic [2:0] AN_TENS     = 3'b101;
  localparam logic [2:0] AN_HUNDREDS = 3'b011;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: snapshot in idle, eight adjust-and-shift
// steps, then publish the three BCD digits with a one-cycle strobe.
module bin2bcd_seq
  import count_disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count,
  output logic [11:0] bcd,
  output logic        bcd_stb
);

  conv_state_e state_q;
  logic [7:0]  sreg_q;
  logic [11:0] acc_q;
  logic [11:0] acc_adj;
  logic [2:0]  step_q;

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      bcd     <= '0;
      bcd_stb <= 1'b0;
    end else begin
      bcd_stb <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sreg_q  <= count;
          acc_q   <= '0;
          step_q  <= '0;
          state_q <= StShift;
        end
        StShift: begin
          {acc_q, sreg_q} <= {acc_adj, sreg_q} << 1;
          step_q          <= step_q + 3'd1;
          if (step_q == 3'd7) state_q <= StLoad;
        end
        StLoad: begin
          bcd     <= acc_q;
          bcd_stb <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/count_display_scan.sv
// Counter display back-end: BCD conversion plus a 3-digit active-low scanner.
// Leading-zero blanking is enabled by defining COUNT_DISP_LZB_EN.
module count_display_scan
  import count_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count,
  output logic [11:0] bcd,
  output logic        bcd_stb,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

  logic [DivW-1:0] div_q;
  logic [1:0]      idx_q;
  logic [1:0]      idx_nxt;
  logic [2:0]      an_nxt;
  logic [3:0]      digit;
  logic [6:0]      seg_nxt;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .bcd     (bcd),
    .bcd_stb (bcd_stb)
  );

  // Display always reads the published bcd register, never the accumulator.
  always_comb begin
    idx_nxt = 2'd0;
    an_nxt  = AN_ONES;
    digit   = bcd[3:0];
    unique case (idx_q)
      2'd0: begin
        idx_nxt = 2'd1;
        an_nxt  = AN_TENS;
        digit   = bcd[7:4];
      end
      2'd1: begin
        idx_nxt = 2'd2;
        an_nxt  = AN_HUNDREDS;
        digit   = bcd[11:8];
      end
      default: begin
        idx_nxt = 2'd0;
        an_nxt  = AN_ONES;
        digit   = bcd[3:0];
      end
    endcase
    seg_nxt = seg_decode(digit);
`ifdef COUNT_DISP_LZB_EN
    if (idx_nxt == 2'd2 && bcd[11:8] == 4'd0) seg_nxt = SEG_BLANK;
    if (idx_nxt == 2'd1 && bcd[11:4] == 8'd0) seg_nxt = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= 2'd0;
      an    <= AN_ONES;
      seg   <= SEG_0;
    end else if (div_q == DivMax) begin
      div_q <= '0;
      idx_q <= idx_nxt;
      an    <= an_nxt;
      seg   <= seg_nxt;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan with two instances (SCAN_DIV 4 and 1)
// sharing clock, reset and count.
module tb_count_display_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  count;

  logic [11:0] bcd4, bcd1;
  logic        stb4, stb1;
  logic [6:0]  seg4, seg1;
  logic [2:0]  an4, an1;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SB = 7'b1111111;

  always #5 clk = ~clk;

  count_display_scan #(.SCAN_DIV(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .bcd     (bcd4),
    .bcd_stb (stb4),
    .seg     (seg4),
    .an      (an4)
  );

  count_display_scan #(.SCAN_DIV(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .bcd     (bcd1),
    .bcd_stb (stb1),
    .seg     (seg1),
    .an      (an1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " seg4"}, {5'd0, seg4}, {5'd0, S0});
    check({tag, " an4"},  {9'd0, an4},  12'h006);
    check({tag, " bcd4"}, bcd4, 12'h000);
    check({tag, " stb4"}, {11'd0, stb4}, 12'h000);
    check({tag, " an1"},  {9'd0, an1},  12'h006);
    check({tag, " stb1"}, {11'd0, stb1}, 12'h000);
  endtask

  task automatic wait_stb(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      found = stb4;
    end
    check({tag, " stb timeout"}, {11'd0, found}, 12'h001);
  endtask

  // Waits for dut4.an to newly switch to the target enable code.
  task automatic wait_an(input string tag, input logic [2:0] target);
    bit         found = 1'b0;
    logic [2:0] prev = an4;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (an4 == target && prev != target) found = 1'b1;
      prev = an4;
    end
    check({tag, " an timeout"}, {11'd0, found}, 12'h001);
  endtask

  initial begin
    logic [2:0] an1_exp [3];
    logic [2:0] an4_exp;
    an1_exp[0] = 3'b101;
    an1_exp[1] = 3'b011;
    an1_exp[2] = 3'b110;

    reset = 1'b1;
    count = 8'd0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_outputs("reset");
    end

    // Full-scale 255, sampled at the first edge with reset low.
    reset = 1'b0;
    count = 8'd255;
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      check("fs stb low", {11'd0, stb4}, 12'h000);
    end
    step();
    check("fs stb", {11'd0, stb4}, 12'h001);
    check("fs bcd", bcd4, 12'h255);
    step();
    check("fs stb drop", {11'd0, stb4}, 12'h000);
    wait_an("fs ones", 3'b110);
    check("fs seg ones", {5'd0, seg4}, {5'd0, S5});
    wait_an("fs tens", 3'b101);
    check("fs seg tens", {5'd0, seg4}, {5'd0, S5});
    wait_an("fs hund", 3'b011);
    check("fs seg hund", {5'd0, seg4}, {5'd0, S2});

    // Value 7: leading zeros shown or blanked depending on build.
    count = 8'd7;
    wait_stb("bl1");
    wait_stb("bl2");
    check("bl bcd", bcd4, 12'h007);
    wait_an("bl hund", 3'b011);
`ifdef COUNT_DISP_LZB_EN
    check("bl seg hund", {5'd0, seg4}, {5'd0, SB});
`else
    check("bl seg hund", {5'd0, seg4}, {5'd0, S0});
`endif
    wait_an("bl ones", 3'b110);
    check("bl seg ones", {5'd0, seg4}, {5'd0, S7});
    wait_an("bl tens", 3'b101);
`ifdef COUNT_DISP_LZB_EN
    check("bl seg tens", {5'd0, seg4}, {5'd0, SB});
`else
    check("bl seg tens", {5'd0, seg4}, {5'd0, S0});
`endif

    // Snapshot: count changes during the third SHIFT cycle.
    wait_stb("snap sync");
    count = 8'd100;
    step();
    step();
    step();
    count = 8'd200;
    for (int i = 0; i < 7; i++) step();
    check("snap stb", {11'd0, stb4}, 12'h001);
    check("snap bcd first", bcd4, 12'h100);
    wait_stb("snap next");
    check("snap bcd next", bcd4, 12'h200);

    // Reset pulsed during SHIFT with count 99.
    wait_stb("rst sync");
    count = 8'd99;
    step();
    step();
    reset = 1'b1;
    step();
    check_reset_outputs("rst mid");
    step();
    check_reset_outputs("rst hold");
    reset = 1'b0;
    // Scan rotation after release: dut1 every cycle, dut4 every 4 cycles.
    for (int k = 0; k < 10; k++) begin
      step();
      an4_exp = (k < 3) ? 3'b110 : (k < 7) ? 3'b101 : 3'b011;
      check("scan an1", {9'd0, an1}, {9'd0, an1_exp[k % 3]});
      check("scan an4", {9'd0, an4}, {9'd0, an4_exp});
      if (k < 9) check("rst no stb", {11'd0, stb4}, 12'h000);
    end
    check("rst stb", {11'd0, stb4}, 12'h001);
    check("rst bcd", bcd4, 12'h099);
    check("rst bcd1", bcd1, 12'h099);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
